// File: rtl/mem_arb.sv
// Data-memory arbiter between the CPU MEM stage and a background loader.
// The loader gets bounded bursts while the CPU waits, and the CPU is never starved.
module mem_arb #(
  parameter int MAX_BURST = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic        w_h,
  input  logic [6:0]  DIR_cpu,
  input  logic [31:0] DI_cpu,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [6:0]  ld_dir,
  input  logic [31:0] ld_di,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        stall_cpu,
  output logic        MEM_RD_o,
  output logic        MEM_WR_o,
  output logic        w_h_o,
  output logic [6:0]  DIR_MEM,
  output logic [31:0] DI_MEM,
  input  logic [31:0] DO_MEM
);

  localparam int WW = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_LD  = 1'b1
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [WW-1:0]   wait_cnt_r;
  logic [WW-1:0]   wait_cnt_s;
  logic [BW-1:0]   burst_cnt_r;
  logic [BW-1:0]   burst_cnt_s;
  logic            cpu_req_s;
  logic            ld_read_s;

  assign cpu_req_s = MEM_RD | MEM_WR;
  assign ld_read_s = (state_r == S_LD) & ld_req & ~ld_we;

  // Ownership decision and fairness counters
  always_comb begin
    next_state_s = state_r;
    wait_cnt_s   = wait_cnt_r;
    burst_cnt_s  = burst_cnt_r;
    case (state_r)
      S_CPU: begin
        burst_cnt_s = {BW{1'b0}};
        if (ld_req && (!cpu_req_s || (wait_cnt_r == WAIT_LAST))) begin
          next_state_s = S_LD;
          wait_cnt_s   = {WW{1'b0}};
        end else if (!ld_req) begin
          wait_cnt_s = {WW{1'b0}};
        end else if (wait_cnt_r != WAIT_LAST) begin
          wait_cnt_s = wait_cnt_r + WW'(1);
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end
      S_LD: begin
        wait_cnt_s = {WW{1'b0}};
        // Leaving S_LD always lasts a full S_CPU cycle, so a forced yield serves the CPU
        if (!ld_req || (cpu_req_s && (burst_cnt_r == BURST_LAST))) begin
          next_state_s = S_CPU;
          burst_cnt_s  = {BW{1'b0}};
        end else if (!cpu_req_s) begin
          burst_cnt_s = {BW{1'b0}};
        end else if (burst_cnt_r != BURST_LAST) begin
          burst_cnt_s = burst_cnt_r + BW'(1);
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
      end
      default: begin
        next_state_s = S_CPU;
        wait_cnt_s   = {WW{1'b0}};
        burst_cnt_s  = {BW{1'b0}};
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state_r     <= S_CPU;
      wait_cnt_r  <= {WW{1'b0}};
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      state_r     <= next_state_s;
      wait_cnt_r  <= wait_cnt_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Memory port mux; a combined CPU read+write is presented as a write only
  always_comb begin
    ld_gnt    = 1'b0;
    stall_cpu = 1'b0;
    MEM_RD_o  = MEM_RD & ~MEM_WR;
    MEM_WR_o  = MEM_WR;
    w_h_o     = w_h;
    DIR_MEM   = DIR_cpu;
    DI_MEM    = DI_cpu;
    case (state_r)
      S_CPU: begin
        ld_gnt    = 1'b0;
        stall_cpu = 1'b0;
      end
      S_LD: begin
        ld_gnt    = ld_req;
        stall_cpu = cpu_req_s;
        MEM_RD_o  = ld_req & ~ld_we;
        MEM_WR_o  = ld_req & ld_we;
        w_h_o     = 1'b0;
        DIR_MEM   = ld_dir;
        DI_MEM    = ld_di;
      end
      default: begin
        ld_gnt    = 1'b0;
        stall_cpu = 1'b0;
      end
    endcase
  end

  // Loader read return, valid for the single cycle after the grant
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      ld_rvalid <= 1'b0;
      ld_rdata  <= 32'd0;
    end else if (ld_read_s) begin
      ld_rvalid <= 1'b1;
      ld_rdata  <= DO_MEM;
    end else begin
      ld_rvalid <= 1'b0;
      ld_rdata  <= ld_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vectors, corner sequences and a
// randomized run against a count-based ownership model.
module tb_mem_arb;

  localparam int MB = 4;
  localparam int MW = 8;

  logic        reloj = 1'b0;
  logic        resetM;
  logic        MEM_RD, MEM_WR, w_h;
  logic [6:0]  DIR_cpu;
  logic [31:0] DI_cpu;
  logic        ld_req, ld_we;
  logic [6:0]  ld_dir;
  logic [31:0] ld_di;
  logic        ld_gnt, ld_rvalid, stall_cpu;
  logic [31:0] ld_rdata;
  logic        MEM_RD_o, MEM_WR_o, w_h_o;
  logic [6:0]  DIR_MEM;
  logic [31:0] DI_MEM, DO_MEM;

  logic [31:0] mem [0:127];
  int          wr_count = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  mem_arb #(.MAX_BURST(MB), .MAX_WAIT(MW)) dut (
    .reloj(reloj), .resetM(resetM),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .w_h(w_h),
    .DIR_cpu(DIR_cpu), .DI_cpu(DI_cpu),
    .ld_req(ld_req), .ld_we(ld_we), .ld_dir(ld_dir), .ld_di(ld_di),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .stall_cpu(stall_cpu),
    .MEM_RD_o(MEM_RD_o), .MEM_WR_o(MEM_WR_o), .w_h_o(w_h_o),
    .DIR_MEM(DIR_MEM), .DI_MEM(DI_MEM), .DO_MEM(DO_MEM)
  );

  always #5 reloj = ~reloj;

  assign DO_MEM = mem[DIR_MEM];

  always @(posedge reloj) begin
    if (MEM_WR_o) begin
      mem[DIR_MEM] <= DI_MEM;
      wr_count     <= wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_RD = 1'b0; MEM_WR = 1'b0; w_h = 1'b0;
    DIR_cpu = 7'd0; DI_cpu = 32'd0;
    ld_req = 1'b0; ld_we = 1'b0; ld_dir = 7'd0; ld_di = 32'd0;
  endtask

  task automatic do_reset();
    resetM = 1'b0;
    idle_inputs();
    repeat (2) @(posedge reloj);
    #1;
    resetM = 1'b1;
  endtask

  typedef struct {
    logic        rd, wr, wh;
    logic [6:0]  dir;
    logic [31:0] di;
    logic        lreq, lwe;
    logic        e_rd, e_wr, e_wh, e_gnt, e_stall;
  } vec_t;

  vec_t vecs [7];

  // model state: who owns the port and how long the other side has been held off
  bit          m_ld;
  int          m_contested;
  int          m_grants;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int wr_before;
    logic cpu_req;
    logic nxt_rvalid;
    logic [31:0] nxt_rdata;
    logic [76:0] exp_v;
    int r;

    for (int i = 0; i < 128; i++) mem[i] <= 32'd0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 7'd3,   32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 7'd127, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 7'd16,  32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 7'd40,  32'h0BAD_F00D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 7'd41,  32'hCAFE_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 7'd42,  32'h0000_0042, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 7'd0,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state with busy inputs
    resetM = 1'b0;
    idle_inputs();
    ld_req = 1'b1; ld_we = 1'b1; MEM_RD = 1'b1;
    #7;
    chk("reset_outputs", 128'({ld_gnt, stall_cpu, ld_rvalid, ld_rdata, MEM_RD_o}),
        128'({1'b0, 1'b0, 1'b0, 32'd0, 1'b1}));
    do_reset();

    // directed vectors in CPU ownership
    for (int i = 0; i < 7; i++) begin
      MEM_RD = vecs[i].rd; MEM_WR = vecs[i].wr; w_h = vecs[i].wh;
      DIR_cpu = vecs[i].dir; DI_cpu = vecs[i].di;
      ld_req = vecs[i].lreq; ld_we = vecs[i].lwe; ld_dir = 7'd99; ld_di = 32'hFFFF_0000;
      @(negedge reloj);
      chk($sformatf("vec%0d", i),
          128'({ld_gnt, stall_cpu, MEM_RD_o, MEM_WR_o, w_h_o, DIR_MEM, DI_MEM}),
          128'({vecs[i].e_gnt, vecs[i].e_stall, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_wh,
                vecs[i].dir, vecs[i].di}));
      tick();
    end
    idle_inputs();
    tick();

    // idle CPU: loader write then read of word 5
    ld_req = 1'b1; ld_we = 1'b1; ld_dir = 7'd5; ld_di = 32'hDEAD_BEEF;
    @(negedge reloj);
    chk("ld_first_cycle_gnt", 128'(ld_gnt), 128'(1'b0));
    tick();
    @(negedge reloj);
    chk("ld_write_gnt", 128'({ld_gnt, stall_cpu, MEM_WR_o, DIR_MEM, DI_MEM}),
        128'({1'b1, 1'b0, 1'b1, 7'd5, 32'hDEAD_BEEF}));
    tick();
    chk("mem5_written", 128'(mem[5]), 128'(32'hDEAD_BEEF));
    ld_we = 1'b0;
    @(negedge reloj);
    chk("ld_read_gnt", 128'({ld_gnt, MEM_RD_o, ld_rvalid}), 128'({1'b1, 1'b1, 1'b0}));
    tick();
    ld_req = 1'b0;
    @(negedge reloj);
    chk("ld_read_data", 128'({ld_rvalid, ld_rdata}), 128'({1'b1, 32'hDEAD_BEEF}));
    tick();
    @(negedge reloj);
    chk("ld_rvalid_one_cycle", 128'(ld_rvalid), 128'(1'b0));
    tick();

    // contended: CPU read held, loader waits MAX_WAIT cycles then bursts MAX_BURST
    MEM_RD = 1'b1; DIR_cpu = 7'd9; ld_req = 1'b1; ld_we = 1'b0; ld_dir = 7'd5;
    n = 0;
    @(negedge reloj);
    while (!ld_gnt && n < 40) begin
      n++;
      tick();
      @(negedge reloj);
    end
    chk("wait_cycles", 128'(n), 128'(MW));
    chk("stall_in_ld", 128'(stall_cpu), 128'(1'b1));
    g = 0;
    while (ld_gnt && g < 20) begin
      g++;
      tick();
      @(negedge reloj);
    end
    chk("burst_grants", 128'(g), 128'(MB));
    chk("cpu_after_yield", 128'({ld_gnt, stall_cpu, MEM_RD_o, DIR_MEM}),
        128'({1'b0, 1'b0, 1'b1, 7'd9}));
    idle_inputs();
    tick();
    tick();

    // reset in the middle of a loader write burst
    ld_req = 1'b1; ld_we = 1'b1; ld_dir = 7'd20; ld_di = 32'h0000_1234;
    tick();
    @(negedge reloj);
    chk("burst_gnt", 128'(ld_gnt), 128'(1'b1));
    tick();
    ld_dir = 7'd21; ld_di = 32'h0000_5555;
    @(negedge reloj);
    resetM = 1'b0;
    #1;
    chk("rst_mid_outputs", 128'({ld_gnt, stall_cpu, MEM_WR_o, MEM_RD_o, ld_rvalid}), 128'(5'd0));
    wr_before = wr_count;
    repeat (3) @(posedge reloj);
    #1;
    chk("rst_no_writes", 128'({wr_count - wr_before, mem[21], mem[20]}),
        128'({32'd0, 32'd0, 32'h0000_1234}));
    resetM = 1'b1;
    ld_we = 1'b0; ld_dir = 7'd20;
    @(negedge reloj);
    chk("post_reset_no_gnt", 128'(ld_gnt), 128'(1'b0));
    tick();
    @(negedge reloj);
    chk("post_reset_gnt", 128'(ld_gnt), 128'(1'b1));
    resetM = 1'b0;
    #1;
    repeat (2) @(posedge reloj);
    #1;
    chk("rst_aborts_read", 128'({ld_rvalid, ld_rdata}), 128'({1'b0, 32'd0}));

    // randomized run against the ownership model
    do_reset();
    m_ld = 1'b0; m_contested = 0; m_grants = 0; m_rvalid = 1'b0; m_rdata = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!(m_ld && (MEM_RD || MEM_WR))) begin
        r = $urandom_range(0, 9);
        MEM_RD = (r < 4) || (r == 6);
        MEM_WR = (r >= 4 && r <= 6);
        w_h = 1'($urandom_range(0, 1));
        DIR_cpu = 7'($urandom_range(0, 15));
        DI_cpu = $urandom;
      end
      ld_req = ($urandom_range(0, 3) != 0);
      ld_we = 1'($urandom_range(0, 1));
      ld_dir = 7'($urandom_range(0, 15));
      ld_di = $urandom;
      @(negedge reloj);
      cpu_req = MEM_RD | MEM_WR;
      if (m_ld)
        exp_v = {ld_req, cpu_req, ld_req & ~ld_we, ld_req & ld_we, 1'b0, ld_dir, ld_di, m_rvalid, m_rdata};
      else
        exp_v = {1'b0, 1'b0, MEM_RD & ~MEM_WR, MEM_WR, w_h, DIR_cpu, DI_cpu, m_rvalid, m_rdata};
      chk($sformatf("rand_c%0d", c),
          128'({ld_gnt, stall_cpu, MEM_RD_o, MEM_WR_o, w_h_o, DIR_MEM, DI_MEM, ld_rvalid, ld_rdata}),
          128'(exp_v));
      nxt_rvalid = m_ld && ld_req && !ld_we;
      nxt_rdata = nxt_rvalid ? mem[ld_dir] : m_rdata;
      if (!m_ld) begin
        if (ld_req && cpu_req) m_contested++;
        else m_contested = 0;
        if (ld_req && (!cpu_req || m_contested >= MW)) begin
          m_ld = 1'b1;
          m_contested = 0;
          m_grants = 0;
        end
      end else begin
        if (ld_req && cpu_req) m_grants++;
        else m_grants = 0;
        if (!ld_req || m_grants >= MB) begin
          m_ld = 1'b0;
          m_grants = 0;
          m_contested = 0;
        end
      end
      m_rvalid = nxt_rvalid;
      m_rdata = nxt_rdata;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive loader grants while the CPU is waiting.
REQ-002 Parameter MAX_WAIT, default 8: maximum cycles the loader waits before it forcibly takes the memory.
REQ-003 reloj  in  1  single clock; all state updates on its rising edge.
REQ-004 resetM  in  1  asynchronous, active-low reset.
REQ-005 MEM_RD, MEM_WR, w_h  in  1 each  CPU MEM-stage read, write and halfword strobes.
REQ-006 DIR_cpu  in  7  CPU word address; DI_cpu  in  32  CPU write data.
REQ-007 ld_req, ld_we  in  1 each  loader request and write-enable (0 = read).
REQ-008 ld_dir  in  7  loader address; ld_di  in  32  loader write data.
REQ-009 ld_gnt  out  1  loader access accepted this cycle.
REQ-010 ld_rvalid  out  1  loader read data valid; ld_rdata  out  32  loader read data.
REQ-011 stall_cpu  out  1  pipeline freeze request (CPU access pending but not served).
REQ-012 MEM_RD_o, MEM_WR_o, w_h_o  out  1 each; DIR_MEM  out  7; DI_MEM  out  32  strobes, address and data to the data memory.
REQ-013 DO_MEM  in  32  memory read data, combinational from DIR_MEM/MEM_RD_o.

Function
REQ-014 cpu_req = MEM_RD | MEM_WR; a simultaneous MEM_RD and MEM_WR SHALL be treated as a write.
REQ-015 FSM has two states: S_CPU (memory owned by CPU) and S_LD (memory owned by loader).
REQ-016 S_CPU -> S_LD when ld_req=1 and cpu_req=0, or when ld_req=1 and wait_cnt==MAX_WAIT-1.
REQ-017 S_LD -> S_CPU when ld_req=0, or when cpu_req=1 and burst_cnt==MAX_BURST-1; otherwise remain in S_LD.
REQ-018 In S_CPU the memory port SHALL carry the CPU signals unchanged, with ld_gnt=0 and stall_cpu=0.
REQ-019 In S_LD the memory port SHALL carry MEM_RD_o=ld_req&~ld_we, MEM_WR_o=ld_req&ld_we, w_h_o=0, DIR_MEM=ld_dir and DI_MEM=ld_di.
REQ-020 In S_LD, ld_gnt=ld_req and stall_cpu=cpu_req.
REQ-021 While cpu_req=1 in S_LD, CPU inputs SHALL be held stable by the pipeline; the arbiter does not latch them.
REQ-022 Loader access takes 1 cycle: a write is committed on the edge ending the ld_gnt cycle; a read is registered into ld_rdata from DO_MEM on that edge, with ld_rvalid=1 for exactly the following cycle.
REQ-023 wait_cnt: increments each S_CPU cycle with ld_req=1 and cpu_req=1, saturating at MAX_WAIT-1; clears on entering S_LD or when ld_req=0.
REQ-024 burst_cnt: increments each S_LD cycle with cpu_req=1 and ld_gnt=1, saturating at MAX_BURST-1; clears on entering S_CPU or when cpu_req=0.
REQ-025 A forced yield (REQ-017) SHALL give the CPU at least 1 S_CPU cycle before the loader is granted again.
REQ-026 Counters SHALL be wide enough to hold MAX_WAIT-1 and MAX_BURST-1 without overflow.

Reset
REQ-027 resetM=0 SHALL immediately force state=S_CPU, wait_cnt=0, burst_cnt=0, ld_rvalid=0 and ld_rdata=0; all outputs then follow the S_CPU rules.
REQ-028 Reset asserted during S_LD SHALL abort the loader access: no write after reset assertion, and no ld_rvalid for the aborted read.
REQ-029 After resetM rises, the first possible loader grant is on the cycle after the transition decision (REQ-016).

Verification
REQ-030 Idle CPU; ld_req=1, ld_we=1, ld_dir=5, ld_di=0xDEADBEEF -> ld_gnt from cycle 2, memory word 5 = 0xDEADBEEF, stall_cpu=0.
REQ-031 Loader reads word 5 -> ld_rvalid=1 one cycle after ld_gnt, ld_rdata=0xDEADBEEF.
REQ-032 CPU MEM_RD held continuously, ld_req=1 -> loader is granted after 8 cycles (MAX_WAIT), stall_cpu=1 during S_LD.
REQ-033 Loader in S_LD with cpu_req=1 -> exactly 4 loader grants, then 1 or more S_CPU cycles with stall_cpu=0.
REQ-034 resetM pulsed low mid-loader-write burst -> outputs return to S_CPU values within the same cycle, ld_rvalid=0, and no further memory writes.
REQ-035 MEM_RD=MEM_WR=1 in S_CPU -> MEM_WR_o=1 passed through, ld_gnt=0.
